// File: rtl/hilo_div_seq.sv
// hilo_div_seq: multi-cycle restoring divider that sequences one HI/LO write per DIV/DIVU
module hilo_div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] opdata1_i,
    input  logic [WIDTH-1:0] opdata2_i,
    input  logic             annul_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             hilo_we_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    typedef enum logic [1:0] {IDLE, DIVZERO, RUN, DONE} state_t;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    state_t state, state_n;
    logic [CW-1:0] cnt;
    logic [WIDTH-1:0] rem, quo, dvs, quo_n, rem_n;
    logic [WIDTH:0] shifted, diff;
    logic qsign, rsign, neg1, neg2, accept, last;
    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end
    // Next-state, status outputs and the combinational restoring step
    always_comb begin
        accept = state == IDLE && start_i && !annul_i;
        neg1 = signed_i & opdata1_i[WIDTH-1];
        neg2 = signed_i & opdata2_i[WIDTH-1];
        shifted = {rem, quo[WIDTH-1]};
        diff = shifted - {1'b0, dvs};
        quo_n = {quo[WIDTH-2:0], ~diff[WIDTH]};
        rem_n = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        last = cnt == LAST;
        busy_o = state == DIVZERO || state == RUN;
        done_o = state == DONE;
        hilo_we_o = done_o;
        state_n = state;
        case (state)
            IDLE:    state_n = accept ? (opdata2_i == '0 ? DIVZERO : RUN) : IDLE;
            DIVZERO: state_n = annul_i ? IDLE : DONE;
            RUN:     state_n = annul_i ? IDLE : (last ? DONE : RUN);
            default: state_n = IDLE;
        endcase
    end
    // Operand capture, iteration, and sign-corrected result load on the way into DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            rem <= '0;
            quo <= '0;
            dvs <= '0;
            qsign <= 1'b0;
            rsign <= 1'b0;
            hi_o <= '0;
            lo_o <= '0;
        end else begin
            if (accept) begin
                quo <= neg1 ? -opdata1_i : opdata1_i;
                dvs <= neg2 ? -opdata2_i : opdata2_i;
                rem <= '0;
                cnt <= '0;
                qsign <= neg1 ^ neg2;
                rsign <= neg1;
            end
            if (state == RUN) begin
                quo <= quo_n;
                rem <= rem_n;
                cnt <= cnt + 1'b1;
            end
            if (state == RUN && last && !annul_i) begin
                lo_o <= qsign ? -quo_n : quo_n;
                hi_o <= rsign ? -rem_n : rem_n;
            end
            if (state == DIVZERO && !annul_i) begin
                lo_o <= '0;
                hi_o <= '0;
            end
        end
    end
endmodule

// File: tb/tb_hilo_div_seq.sv
// tb_hilo_div_seq: directed self-checking bench for the HI/LO divider sequencer
module tb_hilo_div_seq;
    logic clk, rst, start_i, signed_i, annul_i;
    logic [31:0] opdata1_i, opdata2_i;
    logic busy_o, done_o, hilo_we_o;
    logic [31:0] hi_o, lo_o;
    int tests = 0;
    int fails = 0;
    int wc, da;
    logic [31:0] gh, gl;

    hilo_div_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .signed_i(signed_i),
        .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .annul_i(annul_i),
        .busy_o(busy_o), .done_o(done_o), .hilo_we_o(hilo_we_o),
        .hi_o(hi_o), .lo_o(lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Caller is at a negedge in an IDLE cycle; start is driven now and the run is followed lat+1 cycles.
    task automatic do_div(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input logic [31:0] eh, input logic [31:0] el);
        int bc, w, d;
        logic [31:0] h, l;
        bc = 0; w = 0; d = 0; h = '0; l = '0;
        start_i = 1'b1; signed_i = s; opdata1_i = a; opdata2_i = b;
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            if (k == 1) start_i = 1'b0;
            bc += busy_o ? 1 : 0;
            w += hilo_we_o ? 1 : 0;
            if (done_o === 1'b1 && d == 0) begin
                d = k; h = hi_o; l = lo_o;
            end
        end
        check({tag, "_done_cycle"}, 32'(d), 32'(lat));
        check({tag, "_we_pulses"}, 32'(w), 32'd1);
        check({tag, "_busy_cycles"}, 32'(bc), 32'(lat - 1));
        check({tag, "_hi"}, h, eh);
        check({tag, "_lo"}, l, el);
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; signed_i = 1'b0; annul_i = 1'b0;
        opdata1_i = '0; opdata2_i = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_done", {31'd0, done_o}, 32'd0);
        check("rst_hi", hi_o, 32'd0);
        check("rst_lo", lo_o, 32'd0);
        rst = 1'b0;

        do_div("u100_7", 1'b0, 32'd100, 32'd7, 33, 32'd2, 32'd14);
        do_div("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        do_div("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 33, 32'd1, 32'hFFFF_FFFD);
        do_div("u_max_2", 1'b0, 32'hFFFF_FFFF, 32'd2, 33, 32'd1, 32'h7FFF_FFFF);
        do_div("s_div0", 1'b1, 32'hFFFF_FFFB, 32'd0, 2, 32'd0, 32'd0);
        do_div("u_max_2b", 1'b0, 32'hFFFF_FFFF, 32'd2, 33, 32'd1, 32'h7FFF_FFFF);
        do_div("u_div0", 1'b0, 32'd123, 32'd0, 2, 32'd0, 32'd0);
        do_div("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000);
        do_div("u_big", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'd0);

        // annul in cycle T+10, then restart at T+11
        start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd99; opdata2_i = 32'd9;
        wc = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) start_i = 1'b0;
            wc += hilo_we_o ? 1 : 0;
            if (k == 10) annul_i = 1'b1;
        end
        @(negedge clk);
        annul_i = 1'b0;
        check("annul_we", 32'(wc), 32'd0);
        check("annul_idle_busy", {31'd0, busy_o}, 32'd0);
        check("annul_idle_done", {31'd0, done_o}, 32'd0);
        check("annul_hold_hi", hi_o, 32'h8000_0000);
        check("annul_hold_lo", lo_o, 32'd0);
        do_div("after_annul", 1'b0, 32'd1000, 32'd3, 33, 32'd1, 32'd333);

        // start held through RUN and DONE; second request taken in the IDLE cycle after DONE
        start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd50; opdata2_i = 32'd5;
        wc = 0; da = 0; gh = '0; gl = '0;
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            wc += hilo_we_o ? 1 : 0;
            if (done_o === 1'b1 && da == 0) begin
                da = k; gh = hi_o; gl = lo_o;
            end
        end
        check("held_done_cycle", 32'(da), 32'd33);
        check("held_we_pulses", 32'(wc), 32'd1);
        check("held_hi", gh, 32'd0);
        check("held_lo", gl, 32'd10);
        check("held_idle_busy", {31'd0, busy_o}, 32'd0);
        signed_i = 1'b1; opdata1_i = 32'hFFFF_FF9C; opdata2_i = 32'd7;
        wc = 0; da = 0;
        for (int k = 35; k <= 68; k++) begin
            @(negedge clk);
            if (k == 35) begin
                start_i = 1'b0;
                check("held_second_accept", {31'd0, busy_o}, 32'd1);
            end
            wc += hilo_we_o ? 1 : 0;
            if (done_o === 1'b1 && da == 0) begin
                da = k; gh = hi_o; gl = lo_o;
            end
        end
        check("second_done_cycle", 32'(da), 32'd67);
        check("second_we_pulses", 32'(wc), 32'd1);
        check("second_hi", gh, 32'hFFFF_FFFE);
        check("second_lo", gl, 32'hFFFF_FFF2);

        // synchronous reset mid-RUN
        start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd77; opdata2_i = 32'd5;
        wc = 0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) start_i = 1'b0;
            wc += hilo_we_o ? 1 : 0;
        end
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_we_before", 32'(wc), 32'd0);
        check("mid_rst_busy", {31'd0, busy_o}, 32'd0);
        check("mid_rst_done", {31'd0, done_o}, 32'd0);
        check("mid_rst_we", {31'd0, hilo_we_o}, 32'd0);
        check("mid_rst_hi", hi_o, 32'd0);
        check("mid_rst_lo", lo_o, 32'd0);
        rst = 1'b0;
        do_div("after_rst", 1'b0, 32'd100, 32'd7, 33, 32'd2, 32'd14);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
